// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted, merging write FIFO with ordered burst-read pass-through to SDRAM
module dcache_write_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        dcache_sdram_ready,
    input  logic        dcache_sdram_request,
    input  logic [25:0] dcache_sdram_addr,
    input  logic        dcache_sdram_write,
    input  logic        dcache_sdram_burst,
    input  logic [3:0]  dcache_sdram_wstrb,
    input  logic [31:0] dcache_sdram_wdata,
    output logic        dcache_sdram_rvalid,
    output logic [31:0] dcache_sdram_rdata,
    output logic [25:0] dcache_sdram_raddress,
    output logic        dcache_sdram_complete,
    input  logic        wb_sdram_ready,
    output logic        wb_sdram_request,
    output logic [25:0] wb_sdram_addr,
    output logic        wb_sdram_write,
    output logic        wb_sdram_burst,
    output logic [3:0]  wb_sdram_wstrb,
    output logic [31:0] wb_sdram_wdata,
    input  logic        wb_sdram_rvalid,
    input  logic [31:0] wb_sdram_rdata,
    input  logic [25:0] wb_sdram_raddress,
    input  logic        wb_sdram_complete
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

    state_t          r_state;
    logic [23:0]     r_addr [DEPTH];
    logic [3:0]      r_strb [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            r_req;
    logic            r_write;
    logic            r_burst;
    logic [25:0]     r_oaddr;
    logic [3:0]      r_ostrb;
    logic [31:0]     r_odata;

    logic            w_out_free;
    logic            w_pop;
    logic            w_merge;
    logic            w_wr_ready;
    logic            w_rd_ready;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_push;
    logic [AW-1:0]   w_tail;
    logic [AW-1:0]   w_widx;

    always_comb begin
        w_out_free = !r_req || wb_sdram_ready;
        w_pop      = r_count != '0 && r_state == IDLE && w_out_free;
        w_tail     = r_wr - AW'(1);
        // the head leaving this cycle must not be modified, so a single-entry pop blocks merging
        w_merge    = r_count != '0 && dcache_sdram_addr[25:2] == r_addr[w_tail] &&
                     !(r_count == CW'(1) && w_pop);
        w_wr_ready = r_count < CW'(DEPTH) || w_merge;
        w_rd_ready = r_state == IDLE && r_count == '0 && w_out_free;
        dcache_sdram_ready = (dcache_sdram_request && !dcache_sdram_write) ? w_rd_ready : w_wr_ready;
        w_wr_acc   = dcache_sdram_request && dcache_sdram_write && w_wr_ready;
        w_rd_acc   = dcache_sdram_request && !dcache_sdram_write && w_rd_ready;
        w_push     = w_wr_acc && !w_merge;
        w_widx     = w_merge ? w_tail : r_wr;
    end

    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_addr[w_widx] <= dcache_sdram_addr[25:2];
            r_strb[w_widx] <= w_merge ? (r_strb[w_widx] | dcache_sdram_wstrb) : dcache_sdram_wstrb;
            for (int b = 0; b < 4; b++)
                if (dcache_sdram_wstrb[b] || !w_merge)
                    r_data[w_widx][8*b +: 8] <= dcache_sdram_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_req   <= 1'b0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_req   <= (w_pop || w_rd_acc) ? 1'b1 : wb_sdram_ready ? 1'b0 : r_req;
            r_state <= w_rd_acc ? RD_ISSUE :
                       (r_state == RD_ISSUE && wb_sdram_ready) ? RD_WAIT :
                       (r_state == RD_WAIT && wb_sdram_rvalid && wb_sdram_complete) ? IDLE : r_state;
        end
    end

    // refills always arrive as bursts; the request's burst flag is carried through as-is
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_oaddr <= {r_addr[r_rd], 2'b00};
            r_write <= 1'b1;
            r_burst <= 1'b0;
            r_ostrb <= r_strb[r_rd];
            r_odata <= r_data[r_rd];
        end else if (w_rd_acc) begin
            r_oaddr <= dcache_sdram_addr;
            r_write <= 1'b0;
            r_burst <= dcache_sdram_burst;
            r_ostrb <= 4'b0000;
        end
    end

    assign wb_sdram_request      = r_req;
    assign wb_sdram_addr         = r_oaddr;
    assign wb_sdram_write        = r_write;
    assign wb_sdram_burst        = r_burst;
    assign wb_sdram_wstrb        = r_ostrb;
    assign wb_sdram_wdata        = r_odata;
    assign dcache_sdram_rvalid   = wb_sdram_rvalid;
    assign dcache_sdram_rdata    = wb_sdram_rdata;
    assign dcache_sdram_raddress = wb_sdram_raddress;
    assign dcache_sdram_complete = wb_sdram_complete;

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && r_count == CW'(DEPTH)));
    a_read_empty: assert property (@(posedge clock) disable iff (reset)
        !(w_rd_acc && r_count != '0));
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: scoreboard bench for the posted write buffer
module tb_dcache_write_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c_ready;
    logic        c_req = 1'b0;
    logic [25:0] c_addr = '0;
    logic        c_write = 1'b0;
    logic        c_burst = 1'b0;
    logic [3:0]  c_strb = '0;
    logic [31:0] c_data = '0;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic [25:0] c_raddr;
    logic        c_complete;
    logic        w_rdy = 1'b0;
    logic        w_req;
    logic [25:0] w_addr;
    logic        w_write;
    logic        w_burst;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic [25:0] w_raddr = '0;
    logic        w_complete = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] sb [$];
    logic [63:0] t_exp;
    logic [63:0] t_obs;

    always #5 clock = ~clock;

    dcache_write_buffer #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .dcache_sdram_ready(c_ready), .dcache_sdram_request(c_req), .dcache_sdram_addr(c_addr),
        .dcache_sdram_write(c_write), .dcache_sdram_burst(c_burst), .dcache_sdram_wstrb(c_strb),
        .dcache_sdram_wdata(c_data), .dcache_sdram_rvalid(c_rvalid), .dcache_sdram_rdata(c_rdata),
        .dcache_sdram_raddress(c_raddr), .dcache_sdram_complete(c_complete),
        .wb_sdram_ready(w_rdy), .wb_sdram_request(w_req), .wb_sdram_addr(w_addr),
        .wb_sdram_write(w_write), .wb_sdram_burst(w_burst), .wb_sdram_wstrb(w_strb),
        .wb_sdram_wdata(w_data), .wb_sdram_rvalid(w_rvalid), .wb_sdram_rdata(w_rdata),
        .wb_sdram_raddress(w_raddr), .wb_sdram_complete(w_complete)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] txn(input logic [25:0] a, input logic w, input logic b,
                                        input logic [3:0] s, input logic [31:0] d);
        return {a, w, b, s, d};
    endfunction

    // reads are compared without wdata, which carries no meaning for them
    always @(negedge clock) begin
        if (!reset && w_req && w_rdy) begin
            chk("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                t_exp = sb.pop_front();
                t_obs = {w_addr, w_write, w_burst, w_strb, w_data};
                if (t_exp[37]) chk("wb_write", t_obs, t_exp);
                else chk("wb_read", 64'(t_obs[63:32]), 64'(t_exp[63:32]));
            end
        end
    end

    task automatic set_req(input logic [25:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        c_req = 1'b1; c_addr = a; c_write = w; c_burst = !w; c_strb = s; c_data = d;
    endtask

    task automatic wait_acc(input string tag, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clock);
            ok = c_ready;
            @(posedge clock); #1;
        end
        c_req = 1'b0;
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wr(input logic [25:0] a, input logic [3:0] s, input logic [31:0] d, input int lim);
        set_req(a, 1'b1, s, d);
        wait_acc("wr_acc", lim);
    endtask

    task automatic probe_low(input int n);
        repeat (n) begin
            @(negedge clock);
            chk("rdy_low", 64'(c_ready), 64'd0);
            @(posedge clock); #1;
        end
    endtask

    task automatic beat(input int k, input logic [25:0] base);
        w_rvalid = 1'b1; w_rdata = $urandom; w_raddr = base + 26'(4 * k); w_complete = (k == 15);
        @(negedge clock);
        chk("rd_fwd", 64'({c_rvalid, c_rdata, c_raddr, c_complete}),
            64'({w_rvalid, w_rdata, w_raddr, w_complete}));
        chk("beat_hold", 64'(w_req), 64'd0);
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (sb.size() != 0 && i < lim) begin
            @(posedge clock);
            i++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_req", 64'(w_req), 64'd0);
        chk("rst_rdy", 64'(c_ready), 64'd1);
        chk("rst_cnt", 64'(dut.r_count), 64'd0);
        @(posedge clock); #1;

        // fill with the arbiter stalled: one entry sits in the output register, eight in the FIFO
        w_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(26'(4 * i), 4'hF, 32'h1111_0000 + 32'(i), 4);
            if (i < 8) sb.push_back(txn(26'(4 * i), 1'b1, 1'b0, 4'hF, 32'h1111_0000 + 32'(i)));
        end
        chk("cnt_full", 64'(dut.r_count), 64'd8);
        wr(26'h020, 4'b1000, 32'hEE00_0000, 1);
        sb.push_back(txn(26'h020, 1'b1, 1'b0, 4'hF, 32'hEE11_0008));
        set_req(26'h024, 1'b1, 4'hF, 32'h1111_0009);
        probe_low(3);
        w_rdy = 1'b1;
        wait_acc("wr_after_full", 8);
        sb.push_back(txn(26'h024, 1'b1, 1'b0, 4'hF, 32'h1111_0009));
        drain(40);

        w_rdy = 1'b0;
        wr(26'h0F0, 4'hF, 32'h1234_5678, 4);
        sb.push_back(txn(26'h0F0, 1'b1, 1'b0, 4'hF, 32'h1234_5678));
        wr(26'h100, 4'b0001, 32'h0000_00AA, 4);
        wr(26'h100, 4'b0100, 32'h00CC_0000, 4);
        sb.push_back(txn(26'h100, 1'b1, 1'b0, 4'b0101, 32'h00CC_00AA));
        chk("merge_cnt", 64'(dut.r_count), 64'd1);
        w_rdy = 1'b1;
        drain(20);

        w_rdy = 1'b0;
        wr(26'h200, 4'hF, 32'hA0A0_A0A0, 4);
        wr(26'h204, 4'hF, 32'hA1A1_A1A1, 4);
        sb.push_back(txn(26'h200, 1'b1, 1'b0, 4'hF, 32'hA0A0_A0A0));
        sb.push_back(txn(26'h204, 1'b1, 1'b0, 4'hF, 32'hA1A1_A1A1));
        set_req(26'h2000, 1'b0, 4'h0, 32'h0);
        sb.push_back(txn(26'h2000, 1'b0, 1'b1, 4'h0, 32'h0));
        probe_low(3);
        w_rdy = 1'b1;
        wait_acc("rd_acc", 10);
        wr(26'h040, 4'hF, 32'h4040_4040, 4);
        sb.push_back(txn(26'h040, 1'b1, 1'b0, 4'hF, 32'h4040_4040));
        repeat (4) begin
            @(negedge clock);
            chk("hold_req", 64'(w_req), 64'd0);
            @(posedge clock); #1;
        end
        chk("st_wait", 64'(dut.r_state), 64'd2);

        for (int k = 0; k < 16; k++) begin
            beat(k, 26'h2000);
            @(posedge clock); #1;
        end
        w_rvalid = 1'b0; w_complete = 1'b0;
        @(negedge clock);
        chk("st_idle", 64'(dut.r_state), 64'd0);
        @(posedge clock); #1;
        drain(20);

        // queued writes behind an in-flight burst must vanish on reset
        set_req(26'h3000, 1'b0, 4'h0, 32'h0);
        sb.push_back(txn(26'h3000, 1'b0, 1'b1, 4'h0, 32'h0));
        wait_acc("rd_acc2", 4);
        for (int i = 0; i < 3; i++) wr(26'h600 + 26'(4 * i), 4'hF, 32'h6600_0000 + 32'(i), 4);
        chk("cnt_q3", 64'(dut.r_count), 64'd3);
        for (int k = 0; k < 16; k++) begin
            reset = (k == 2);
            beat(k, 26'h3000);
            if (k == 3) begin
                chk("rst_mid_req", 64'(w_req), 64'd0);
                chk("rst_mid_cnt", 64'(dut.r_count), 64'd0);
            end
            @(posedge clock); #1;
        end
        w_rvalid = 1'b0; w_complete = 1'b0;
        wr(26'h500, 4'hF, 32'h5555_5555, 4);
        sb.push_back(txn(26'h500, 1'b1, 1'b0, 4'hF, 32'h5555_5555));
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
